// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit with a 2-entry {pc, inst} queue and redirect discard
// A request stays stable until accepted; a redirect while a request is stalled parks in DISCARD.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCsel,
    input  logic [31:0] target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    typedef enum logic [1:0] {START, FETCH, DISCARD} state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] hold_addr;
    logic [1:0]  count;
    logic [31:0] pc0, pc1, in0, in1;

    logic redirect, push, pop;

    assign imem_req   = (state == DISCARD) || ((state == FETCH) && (count != 2'd2));
    assign imem_addr  = (state == DISCARD) ? hold_addr : fetch_pc;
    assign inst_valid = (count != 2'd0);
    assign inst       = inst_valid ? in0 : 32'd0;
    assign inst_pc    = inst_valid ? pc0 : 32'd0;

    assign redirect = PCsel && (state != START);
    assign push     = (state == FETCH) && imem_req && imem_ready && !PCsel;
    assign pop      = inst_valid && inst_ready && !PCsel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= START;
            fetch_pc  <= RESET_PC;
            hold_addr <= RESET_PC;
            count     <= 2'd0;
            pc0       <= 32'd0;
            pc1       <= 32'd0;
            in0       <= 32'd0;
            in1       <= 32'd0;
        end else begin
            case (state)
                START: state <= FETCH;
                FETCH: begin
                    // Stalled request must still complete; remember its address.
                    if (redirect && imem_req && !imem_ready) begin
                        state     <= DISCARD;
                        hold_addr <= fetch_pc;
                    end
                end
                DISCARD: begin
                    if (imem_ready)
                        state <= FETCH;
                end
                default: state <= START;
            endcase

            if (redirect)
                fetch_pc <= target & ~32'h3;
            else if (push)
                fetch_pc <= fetch_pc + 32'd4;

            if (redirect)
                count <= 2'd0;
            else if (push && !pop)
                count <= count + 2'd1;
            else if (pop && !push)
                count <= count - 2'd1;

            // Slot 0 is always the head; pop shifts slot 1 down.
            if (push && pop) begin
                pc0 <= fetch_pc;
                in0 <= imem_rdata;
            end else if (pop) begin
                pc0 <= pc1;
                in0 <= in1;
            end else if (push) begin
                if (count == 2'd0) begin
                    pc0 <= fetch_pc;
                    in0 <= imem_rdata;
                end else begin
                    pc1 <= fetch_pc;
                    in1 <= imem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit against a queue-based model
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PCsel = 1'b0;
    logic [31:0] target = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_unit #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .PCsel(PCsel), .target(target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst(inst),
        .inst_pc(inst_pc), .inst_ready(inst_ready)
    );

    always #5 clk = ~clk;

    // Reference model: a started flag, a pending-discard flag, and a queue of fetched words.
    bit          m_started;
    bit          m_discard;
    logic [31:0] m_hold;
    logic [31:0] m_pc;
    logic [31:0] q_pc[$];
    logic [31:0] q_in[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started = 0;
        m_discard = 0;
        m_hold    = RPC;
        m_pc      = RPC;
        q_pc.delete();
        q_in.delete();
    endtask

    task automatic check_outputs();
        bit exp_req;
        exp_req = m_started && (m_discard || q_pc.size() < 2);
        check("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        check("imem_addr", imem_addr, m_discard ? m_hold : m_pc);
        check("inst_valid", {31'd0, inst_valid}, {31'd0, q_pc.size() != 0});
        check("inst", inst, (q_in.size() != 0) ? q_in[0] : 32'd0);
        check("inst_pc", inst_pc, (q_pc.size() != 0) ? q_pc[0] : 32'd0);
    endtask

    task automatic model_update();
        bit req;
        if (!m_started) begin
            m_started = 1;
        end else if (m_discard) begin
            if (PCsel) m_pc = {target[31:2], 2'b00};
            if (imem_ready) m_discard = 0;
        end else begin
            req = q_pc.size() < 2;
            if (PCsel) begin
                q_pc.delete();
                q_in.delete();
                if (req && !imem_ready) begin
                    m_discard = 1;
                    m_hold    = m_pc;
                end
                m_pc = {target[31:2], 2'b00};
            end else begin
                if (inst_ready && q_pc.size() > 0) begin
                    void'(q_pc.pop_front());
                    void'(q_in.pop_front());
                end
                if (req && imem_ready) begin
                    q_pc.push_back(m_pc);
                    q_in.push_back(imem_rdata);
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    // Called at a negedge: check, drive, advance one clock, return at the next negedge.
    task automatic step(input logic p, input logic [31:0] t, input logic r, input logic ir);
        check_outputs();
        PCsel      = p;
        target     = t;
        imem_ready = r;
        imem_rdata = $urandom;
        inst_ready = ir;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    // Asynchronous reset taken mid-cycle; outputs must clear with no clock edge.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, RPC);
        check("rst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_pc", inst_pc, 32'd0);
        PCsel = 1'b0;
        imem_ready = 1'b0;
        inst_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // Streaming
        repeat (8) step(1'b0, 32'd0, 1'b1, 1'b1);
        // Backpressure then release
        repeat (5) step(1'b0, 32'd0, 1'b1, 1'b0);
        check("bp_full_valid", {31'd0, inst_valid}, 32'd1);
        repeat (5) step(1'b0, 32'd0, 1'b1, 1'b1);
        // Redirect on hit
        step(1'b1, 32'h0000_0102, 1'b1, 1'b1);
        check("hit_addr", imem_addr, 32'h0000_0100);
        check("hit_flush", {31'd0, inst_valid}, 32'd0);
        repeat (3) step(1'b0, 32'd0, 1'b1, 1'b1);
        // Redirect on miss
        step(1'b1, 32'h0000_0010, 1'b1, 1'b1);
        step(1'b1, 32'h0000_0080, 1'b0, 1'b1);
        check("miss_hold", imem_addr, 32'h0000_0010);
        repeat (2) step(1'b0, 32'd0, 1'b0, 1'b1);
        check("miss_hold2", imem_addr, 32'h0000_0010);
        step(1'b0, 32'd0, 1'b1, 1'b1);
        check("miss_next", imem_addr, 32'h0000_0080);
        check("miss_drop", {31'd0, inst_valid}, 32'd0);
        repeat (3) step(1'b0, 32'd0, 1'b1, 1'b1);
        // Wrap
        step(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        check("wrap_pc", imem_addr, 32'h0000_0000);
        check("wrap_head", inst_pc, 32'hFFFF_FFFC);
        repeat (3) step(1'b0, 32'd0, 1'b1, 1'b1);
        // Async reset while in DISCARD
        step(1'b1, 32'h0000_0040, 1'b1, 1'b1);
        step(1'b1, 32'h0000_0200, 1'b0, 1'b1);
        check("disc_req", {31'd0, imem_req}, 32'd1);
        do_reset();
        repeat (2) step(1'b0, 32'd0, 1'b1, 1'b1);
        check("resume_pc", inst_pc, RPC);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) == 0,
                     ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom,
                     $urandom_range(0, 3) != 0,
                     $urandom_range(0, 2) != 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
